// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RV32I decode types, encodings and control constants
package core_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } opcode_t;

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SRL_SRA = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_PASS_B = 5'd10;
    localparam logic [4:0] ALU_MUL    = 5'd16;
    localparam logic [4:0] ALU_MULH   = 5'd17;
    localparam logic [4:0] ALU_MULHSU = 5'd18;
    localparam logic [4:0] ALU_MULHU  = 5'd19;
    localparam logic [4:0] ALU_DIV    = 5'd20;
    localparam logic [4:0] ALU_DIVU   = 5'd21;
    localparam logic [4:0] ALU_REM    = 5'd22;
    localparam logic [4:0] ALU_REMU   = 5'd23;

    localparam logic       OP1_RS1    = 1'b0;
    localparam logic       OP1_PC     = 1'b1;
    localparam logic       OP2_RS2    = 1'b0;
    localparam logic       OP2_IMM    = 1'b1;

    localparam logic [1:0] WB_ALU     = 2'd0;
    localparam logic [1:0] WB_MEM     = 2'd1;
    localparam logic [1:0] WB_PC4     = 2'd2;

    typedef struct packed {
        logic [4:0] rf_rsel1;
        logic [4:0] rf_rsel2;
        logic [4:0] rf_wsel;
        logic       rf_wen;
        logic       dm_wen;
        logic [1:0] rf_wdata_sel;
        logic       alu_op1_sel;
        logic       alu_op2_sel;
        logic [4:0] alu_operation;
        logic [2:0] branch_condition;
    } ctrl_bundle_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } id_state_t;

    // Base ALU code for OP / OP-IMM; alt selects SUB or SRA where funct7[5] matters
    function automatic logic [4:0] alu_base(input logic [2:0] funct3, input logic alt);
        logic [4:0] code;
        case (funct3)
            F3_ADD_SUB: code = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     code = ALU_SLL;
            F3_SLT:     code = ALU_SLT;
            F3_SLTU:    code = ALU_SLTU;
            F3_XOR:     code = ALU_XOR;
            F3_SRL_SRA: code = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      code = ALU_OR;
            default:    code = ALU_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational RV32I(+M) control decoder
module instr_decoder #(
    parameter int M_EXT = 0
) (
    input  logic [31:0]            instruction,
    output core_pkg::ctrl_bundle_t bundle,
    output logic                   illegal,
    output logic                   uses_rs1,
    output logic                   uses_rs2
);
    import core_pkg::*;

    localparam logic HAS_M = (M_EXT != 0);

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];

    // Opcode/funct decode; illegal encodings leave the whole bundle zeroed
    always_comb begin
        bundle   = '0;
        illegal  = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OPC_LUI: begin
                bundle.rf_wsel       = rd;
                bundle.rf_wen        = 1'b1;
                bundle.alu_op2_sel   = OP2_IMM;
                bundle.alu_operation = ALU_PASS_B;
            end
            OPC_AUIPC: begin
                bundle.rf_wsel       = rd;
                bundle.rf_wen        = 1'b1;
                bundle.alu_op1_sel   = OP1_PC;
                bundle.alu_op2_sel   = OP2_IMM;
                bundle.alu_operation = ALU_ADD;
            end
            OPC_JAL: begin
                bundle.rf_wsel       = rd;
                bundle.rf_wen        = 1'b1;
                bundle.rf_wdata_sel  = WB_PC4;
                bundle.alu_op1_sel   = OP1_PC;
                bundle.alu_op2_sel   = OP2_IMM;
                bundle.alu_operation = ALU_ADD;
            end
            OPC_JALR: begin
                uses_rs1             = 1'b1;
                bundle.rf_rsel1      = rs1;
                bundle.rf_wsel       = rd;
                bundle.rf_wen        = 1'b1;
                bundle.rf_wdata_sel  = WB_PC4;
                bundle.alu_op2_sel   = OP2_IMM;
                bundle.alu_operation = ALU_ADD;
            end
            OPC_BRANCH: begin
                uses_rs1                = 1'b1;
                uses_rs2                = 1'b1;
                bundle.rf_rsel1         = rs1;
                bundle.rf_rsel2         = rs2;
                bundle.alu_operation    = ALU_SUB;
                bundle.branch_condition = funct3;
            end
            OPC_LOAD: begin
                uses_rs1             = 1'b1;
                bundle.rf_rsel1      = rs1;
                bundle.rf_wsel       = rd;
                bundle.rf_wen        = 1'b1;
                bundle.rf_wdata_sel  = WB_MEM;
                bundle.alu_op2_sel   = OP2_IMM;
                bundle.alu_operation = ALU_ADD;
            end
            OPC_STORE: begin
                uses_rs1             = 1'b1;
                uses_rs2             = 1'b1;
                bundle.rf_rsel1      = rs1;
                bundle.rf_rsel2      = rs2;
                bundle.dm_wen        = 1'b1;
                bundle.alu_op2_sel   = OP2_IMM;
                bundle.alu_operation = ALU_ADD;
            end
            OPC_OP_IMM: begin
                uses_rs1             = 1'b1;
                bundle.rf_rsel1      = rs1;
                bundle.rf_wsel       = rd;
                bundle.rf_wen        = 1'b1;
                bundle.alu_op2_sel   = OP2_IMM;
                bundle.alu_operation = alu_base(funct3, (funct3 == F3_SRL_SRA) && funct7[5]);
            end
            OPC_OP: begin
                if (funct7 == F7_MULDIV && !HAS_M) begin
                    illegal = 1'b1;
                end else begin
                    uses_rs1        = 1'b1;
                    uses_rs2        = 1'b1;
                    bundle.rf_rsel1 = rs1;
                    bundle.rf_rsel2 = rs2;
                    bundle.rf_wsel  = rd;
                    bundle.rf_wen   = 1'b1;
                    if (funct7 == F7_MULDIV) begin
                        bundle.alu_operation = ALU_MUL | {2'b00, funct3};
                    end else begin
                        bundle.alu_operation = alu_base(funct3,
                            ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA)) && funct7[5]);
                    end
                end
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered ID/EX decode stage with load-use interlock and flush
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int M_EXT = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [31:0]      if_instruction,
    input  logic [XLEN-1:0]  if_pc,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             id_valid,
    output logic [XLEN-1:0]  id_pc,
    output logic [4:0]       RF_rsel1,
    output logic [4:0]       RF_rsel2,
    output logic [4:0]       RF_wsel,
    output logic             RF_wen,
    output logic             DM_wen,
    output logic [1:0]       RF_wdata_sel,
    output logic             ALU_OP1_SEL,
    output logic             ALU_OP2_SEL,
    output logic [4:0]       ALU_Operation,
    output logic [2:0]       branch_condition,
    output logic             id_illegal,
    output logic [CNT_W-1:0] stall_count
);
    import core_pkg::*;

    ctrl_bundle_t     dec_bundle;
    ctrl_bundle_t     bundle_q;
    logic             dec_illegal;
    logic             dec_uses_rs1;
    logic             dec_uses_rs2;
    logic [XLEN-1:0]  pc_q;
    logic             illegal_q;
    logic [CNT_W-1:0] stall_q;
    id_state_t        state_q;
    id_state_t        state_d;

    logic held_load;
    logic rs1_match;
    logic rs2_match;
    logic hazard;
    logic accept;
    logic stall_inc;

    instr_decoder #(
        .M_EXT(M_EXT)
    ) u_instr_decoder (
        .instruction(if_instruction),
        .bundle     (dec_bundle),
        .illegal    (dec_illegal),
        .uses_rs1   (dec_uses_rs1),
        .uses_rs2   (dec_uses_rs2)
    );

    // Only loads select memory write-back, so that field identifies a held load
    assign id_valid  = (state_q == ST_FULL);
    assign held_load = id_valid && (bundle_q.rf_wdata_sel == WB_MEM) && (bundle_q.rf_wsel != 5'd0);
    assign rs1_match = dec_uses_rs1 && (if_instruction[19:15] == bundle_q.rf_wsel);
    assign rs2_match = dec_uses_rs2 && (if_instruction[24:20] == bundle_q.rf_wsel);
    assign hazard    = held_load && (rs1_match || rs2_match);
    assign if_ready  = (!id_valid || ex_ready) && !hazard && !flush;
    assign accept    = if_valid && if_ready;
    assign stall_inc = if_valid && hazard && ex_ready && !flush;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: flush wins, then accept, then a drain empties the stage
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (accept) begin
            state_d = ST_FULL;
        end else if ((state_q == ST_FULL) && ex_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // ID/EX bundle register, loaded only on an accepted instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bundle_q  <= '0;
            pc_q      <= '0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            bundle_q  <= dec_bundle;
            pc_q      <= if_pc;
            illegal_q <= dec_illegal;
        end
    end

    // Saturating count of hazard bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (stall_inc && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign id_pc            = pc_q;
    assign RF_rsel1         = bundle_q.rf_rsel1;
    assign RF_rsel2         = bundle_q.rf_rsel2;
    assign RF_wsel          = bundle_q.rf_wsel;
    assign RF_wen           = bundle_q.rf_wen;
    assign DM_wen           = bundle_q.dm_wen;
    assign RF_wdata_sel     = bundle_q.rf_wdata_sel;
    assign ALU_OP1_SEL      = bundle_q.alu_op1_sel;
    assign ALU_OP2_SEL      = bundle_q.alu_op2_sel;
    assign ALU_Operation    = bundle_q.alu_operation;
    assign branch_condition = bundle_q.branch_condition;
    assign id_illegal       = illegal_q;
    assign stall_count      = stall_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage against a behavioural pipeline model
module tb_decode_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;
    localparam int SMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             if_valid = 1'b0;
    logic [31:0]      if_instruction = '0;
    logic [XLEN-1:0]  if_pc = '0;
    logic             flush = 1'b0;
    logic             ex_ready = 1'b0;

    logic             if_ready, id_valid, RF_wen, DM_wen, ALU_OP1_SEL, ALU_OP2_SEL, id_illegal;
    logic [XLEN-1:0]  id_pc;
    logic [4:0]       RF_rsel1, RF_rsel2, RF_wsel, ALU_Operation;
    logic [1:0]       RF_wdata_sel;
    logic [2:0]       branch_condition;
    logic [CNT_W-1:0] stall_count;

    logic             n_if_ready, n_id_valid, n_RF_wen, n_DM_wen, n_ALU_OP1_SEL, n_ALU_OP2_SEL, n_id_illegal;
    logic [XLEN-1:0]  n_id_pc;
    logic [4:0]       n_RF_rsel1, n_RF_rsel2, n_RF_wsel, n_ALU_Operation;
    logic [1:0]       n_RF_wdata_sel;
    logic [2:0]       n_branch_condition;
    logic [CNT_W-1:0] n_stall_count;

    decode_stage #(.XLEN(XLEN), .M_EXT(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
        .if_instruction(if_instruction), .if_pc(if_pc), .flush(flush), .ex_ready(ex_ready),
        .id_valid(id_valid), .id_pc(id_pc), .RF_rsel1(RF_rsel1), .RF_rsel2(RF_rsel2),
        .RF_wsel(RF_wsel), .RF_wen(RF_wen), .DM_wen(DM_wen), .RF_wdata_sel(RF_wdata_sel),
        .ALU_OP1_SEL(ALU_OP1_SEL), .ALU_OP2_SEL(ALU_OP2_SEL), .ALU_Operation(ALU_Operation),
        .branch_condition(branch_condition), .id_illegal(id_illegal), .stall_count(stall_count)
    );

    decode_stage #(.XLEN(XLEN), .M_EXT(0), .CNT_W(CNT_W)) dut_nom (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(n_if_ready),
        .if_instruction(if_instruction), .if_pc(if_pc), .flush(flush), .ex_ready(ex_ready),
        .id_valid(n_id_valid), .id_pc(n_id_pc), .RF_rsel1(n_RF_rsel1), .RF_rsel2(n_RF_rsel2),
        .RF_wsel(n_RF_wsel), .RF_wen(n_RF_wen), .DM_wen(n_DM_wen), .RF_wdata_sel(n_RF_wdata_sel),
        .ALU_OP1_SEL(n_ALU_OP1_SEL), .ALU_OP2_SEL(n_ALU_OP2_SEL), .ALU_Operation(n_ALU_Operation),
        .branch_condition(n_branch_condition), .id_illegal(n_id_illegal), .stall_count(n_stall_count)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail = 0;
    bit          m_valid = 1'b0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_pc = '0;
    int          m_stall = 0;
    logic        last_rdy;

    function automatic logic [31:0] r_type(input int f7, input int rs2, input int rs1, input int f3, input int rd, input int op);
        return (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
    endfunction

    function automatic bit ref_legal(input logic [31:0] i, input bit mx);
        case (i[6:0])
            7'h03, 7'h13, 7'h17, 7'h23, 7'h37, 7'h63, 7'h67, 7'h6F: return 1'b1;
            7'h33: return (i[31:25] == 7'h01) ? mx : 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit ref_reads_rs1(input logic [31:0] i, input bit mx);
        return ref_legal(i, mx) && !(i[6:0] inside {7'h37, 7'h17, 7'h6F});
    endfunction

    function automatic bit ref_reads_rs2(input logic [31:0] i, input bit mx);
        return ref_legal(i, mx) && (i[6:0] inside {7'h33, 7'h23, 7'h63});
    endfunction

    // Expected bundle {rsel1,rsel2,wsel,rf_wen,dm_wen,wb,op1,op2,alu,br}
    function automatic logic [28:0] ref_fields(input logic [31:0] i, input bit mx);
        int    base[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        logic [6:0] op = i[6:0];
        int    f3 = int'(i[14:12]);
        bit    lg = ref_legal(i, mx);
        bit    wr = lg && !(op inside {7'h23, 7'h63});
        logic [4:0] rs1 = ref_reads_rs1(i, mx) ? i[19:15] : 5'd0;
        logic [4:0] rs2 = ref_reads_rs2(i, mx) ? i[24:20] : 5'd0;
        logic [4:0] rd  = wr ? i[11:7] : 5'd0;
        logic [1:0] wb  = !lg ? 2'd0 : (op == 7'h03) ? 2'd1 : (op inside {7'h6F, 7'h67}) ? 2'd2 : 2'd0;
        bit    o1 = lg && (op inside {7'h17, 7'h6F});
        bit    o2 = lg && !(op inside {7'h33, 7'h63});
        int    alu = 0;
        logic [2:0] br = (lg && op == 7'h63) ? i[14:12] : 3'd0;
        if (!lg) alu = 0;
        else if (op == 7'h37) alu = 10;
        else if (op == 7'h63) alu = 1;
        else if (op == 7'h33 && i[31:25] == 7'h01) alu = 16 + f3;
        else if (op inside {7'h33, 7'h13}) begin
            if (f3 == 0) alu = (op == 7'h33 && i[30]) ? 1 : 0;
            else if (f3 == 5) alu = i[30] ? 7 : 6;
            else alu = base[f3];
        end
        return {rs1, rs2, rd, wr, lg && op == 7'h23, wb, o1, o2, 5'(alu), br};
    endfunction

    function automatic bit ref_hazard(input logic [31:0] i);
        logic [4:0] rd = m_instr[11:7];
        if (!m_valid || m_instr[6:0] != 7'h03 || rd == 5'd0) return 1'b0;
        return (ref_reads_rs1(i, 1'b1) && i[19:15] == rd) || (ref_reads_rs2(i, 1'b1) && i[24:20] == rd);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops[11] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h7F, 7'h0F};
        logic [6:0] f7s[3] = '{7'h00, 7'h20, 7'h01};
        logic [31:0] i = $urandom;
        i[6:0]   = ops[$urandom_range(0, 10)];
        i[11:7]  = 5'($urandom_range(0, 7));
        i[19:15] = 5'($urandom_range(0, 7));
        i[24:20] = 5'($urandom_range(0, 7));
        if (i[6:0] == 7'h33) i[31:25] = f7s[$urandom_range(0, 2)];
        return i;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc, input bit fl, input bit er);
        if_valid = v;
        if_instruction = ins;
        if_pc = pc;
        flush = fl;
        ex_ready = er;
    endtask

    // One clock: check handshake mid-cycle, advance model at the edge, check held outputs after it
    task automatic tick();
        bit hz, rdy;
        #3;
        hz = ref_hazard(if_instruction);
        rdy = (!m_valid || ex_ready) && !hz && !flush;
        last_rdy = if_ready;
        check("if_ready", if_ready, rdy);
        @(posedge clk);
        if (if_valid && hz && ex_ready && !flush && m_stall < SMAX) m_stall++;
        if (flush) m_valid = 1'b0;
        else if (if_valid && rdy) begin
            m_valid = 1'b1;
            m_instr = if_instruction;
            m_pc = if_pc;
        end else if (ex_ready) m_valid = 1'b0;
        #1;
        check("id_valid", id_valid, m_valid);
        check("stall_count", stall_count, m_stall);
        if (m_valid) begin
            check("id_pc", id_pc, m_pc);
            check("bundle", {RF_rsel1, RF_rsel2, RF_wsel, RF_wen, DM_wen, RF_wdata_sel, ALU_OP1_SEL,
                             ALU_OP2_SEL, ALU_Operation, branch_condition}, ref_fields(m_instr, 1'b1));
            check("id_illegal", id_illegal, !ref_legal(m_instr, 1'b1));
        end
    endtask

    logic [31:0] i_addi, i_add2, i_lw, i_add6_5, i_add6_7, i_beq, i_mul;

    initial begin
        i_addi   = r_type(0, 5, 0, 0, 1, 7'h13);
        i_add2   = r_type(0, 1, 1, 0, 2, 7'h33);
        i_lw     = r_type(0, 0, 2, 2, 5, 7'h03);
        i_add6_5 = r_type(0, 1, 5, 0, 6, 7'h33);
        i_add6_7 = r_type(0, 1, 7, 0, 6, 7'h33);
        i_beq    = r_type(0, 2, 1, 0, 8, 7'h63);
        i_mul    = r_type(1, 2, 1, 0, 3, 7'h33);

        // Reset state
        #12;
        check("rst_id_valid", id_valid, 0);
        check("rst_bundle", {RF_rsel1, RF_rsel2, RF_wsel, RF_wen, DM_wen, RF_wdata_sel, ALU_Operation}, 0);
        check("rst_id_pc", id_pc, 0);
        check("rst_stall", stall_count, 0);
        check("rst_if_ready", if_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Throughput
        drive(1, i_addi, 32'h100, 0, 1); tick();
        check("tp_alu_addi", ALU_Operation, 0);
        check("tp_rsel2_addi", RF_rsel2, 0);
        drive(1, i_add2, 32'h104, 0, 1); tick();
        check("tp_valid_add", id_valid, 1);
        check("tp_alu_add", ALU_Operation, 0);
        check("tp_rsel2_add", RF_rsel2, 1);

        // Load-use: one bubble then accept
        drive(1, i_lw, 32'h108, 0, 1); tick();
        drive(1, i_add6_5, 32'h10C, 0, 1); tick();
        check("lu_bubble_ready", last_rdy, 0);
        check("lu_bubble_valid", id_valid, 0);
        check("lu_stall", stall_count, 1);
        tick();
        check("lu_accept_ready", last_rdy, 1);
        check("lu_accept_pc", id_pc, 32'h10C);
        check("lu_rsel1", RF_rsel1, 5);

        // Load followed by an independent instruction
        drive(1, i_lw, 32'h110, 0, 1); tick();
        drive(1, i_add6_7, 32'h114, 0, 1); tick();
        check("nb_ready", last_rdy, 1);
        check("nb_pc", id_pc, 32'h114);
        check("nb_stall", stall_count, 1);

        // Back-pressure with a held beq
        drive(1, i_beq, 32'h118, 0, 1); tick();
        for (int k = 0; k < 3; k++) begin
            drive(1, i_addi, 32'h11C, 0, 0); tick();
            check("bp_ready", last_rdy, 0);
            check("bp_pc", id_pc, 32'h118);
            check("bp_brcond", branch_condition, 0);
            check("bp_rsel2", RF_rsel2, 2);
        end
        drive(0, i_addi, 32'h11C, 0, 1); tick();
        check("bp_drain", id_valid, 0);

        // Flush while full with an offered instruction
        drive(1, i_addi, 32'h120, 0, 1); tick();
        drive(1, i_add2, 32'h124, 1, 1); tick();
        check("fl_valid", id_valid, 0);
        drive(0, 0, 0, 0, 1); tick();
        check("fl_gone", id_valid, 0);

        // Flush together with a hazard counts no stall
        drive(1, i_lw, 32'h128, 0, 1); tick();
        drive(1, i_add6_5, 32'h12C, 1, 1); tick();
        check("flhz_stall", stall_count, 1);
        check("flhz_valid", id_valid, 0);

        // M extension, enabled and disabled instances
        drive(0, 0, 0, 1, 1); tick();
        drive(1, i_mul, 32'h130, 0, 1); tick();
        check("m_alu", ALU_Operation, 16);
        check("m_illegal", id_illegal, 0);
        check("nom_valid", n_id_valid, 1);
        check("nom_illegal", n_id_illegal, 1);
        check("nom_rf_wen", n_RF_wen, 0);
        drive(1, 32'h0000007F, 32'h134, 0, 1); tick();
        check("op7f_illegal", id_illegal, 1);
        check("op7f_rf_wen", RF_wen, 0);

        // Randomised traffic against the model
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 3) != 0, rand_instr(), {$urandom_range(0, 32'h3FFF), 2'b00},
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
            tick();
        end

        // Asynchronous reset mid-stream
        drive(0, 0, 0, 1, 1); tick();
        drive(1, i_addi, 32'h200, 0, 0); tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_valid", id_valid, 0);
        check("arst_pc", id_pc, 0);
        check("arst_bundle", {RF_rsel1, RF_wsel, RF_wen, ALU_OP2_SEL, id_illegal}, 0);
        check("arst_stall", stall_count, 0);
        check("arst_ready", if_ready, 1);
        m_valid = 1'b0;
        m_stall = 0;
        drive(0, 0, 0, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Saturation of the stall counter
        for (int k = 0; k < SMAX + 2; k++) begin
            drive(1, i_lw, 32'h300, 0, 1); tick();
            drive(1, i_add6_5, 32'h304, 0, 1); tick();
            tick();
        end
        check("sat_stall", stall_count, SMAX);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode stage for the pipelined RV32I core. Sits between fetch and execute. Decodes the incoming instruction into the standard control bundle and holds it in an ID/EX register with valid/ready handshakes on both sides. Adds what the combinational control decoder lacks: load-use interlock, flush, optional M-extension decode, illegal-instruction flagging and a stall counter.

## Interface
- `XLEN`, 32: PC width.
- `M_EXT`, 0: 1 decodes MUL/DIV/REM (funct7 = 7'b0000001); 0 flags those encodings illegal.
- `CNT_W`, 16: stall counter width.

- `clk`  in  1  clock. Everything updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_valid`  in  1  fetch offers an instruction.
- `if_ready`  out  1  stage accepts the instruction this cycle.
- `if_instruction`  in  32  offered instruction.
- `if_pc`  in  XLEN  PC of the offered instruction.
- `flush`  in  1  kill the held and incoming instructions (branch mispredict or trap).
- `ex_ready`  in  1  execute accepts the held bundle.
- `id_valid`  out  1  held bundle is valid.
- `id_pc`  out  XLEN  PC of the held instruction.
- `RF_rsel1`, `RF_rsel2`, `RF_wsel`  out  5 each  register selects.
- `RF_wen`, `DM_wen`  out  1 each  register-file and data-memory write enables.
- `RF_wdata_sel`  out  2  register write-back source.
- `ALU_OP1_SEL`, `ALU_OP2_SEL`  out  1 each  ALU operand selects.
- `ALU_Operation`  out  5  ALU operation. Base codes 0–15 are unchanged; M codes are 16–23, in funct3 order.
- `branch_condition`  out  3  branch funct3; 0 when the instruction is not a branch.
- `id_illegal`  out  1  held instruction has an unknown opcode, or is an M op while `M_EXT`=0.
- `stall_count`  out  CNT_W  count of hazard bubbles; saturates.

## Operation
- **Combinational decode.** Same opcode, funct3 and funct7 mapping as the existing control signals. JALR is treated as I-type. LOAD sets `RF_wen`=1 and selects data-memory write-back. Unused register selects are forced to 0.
- **Hazard.** `hazard` = `id_valid` & the held instruction is a LOAD & `RF_wsel`≠0 & (incoming rs1 = `RF_wsel`, or incoming rs2 = `RF_wsel` when the incoming instruction reads rs2). rs2 is read by R-, S- and B-type.
- **Ready.** `if_ready` = (!`id_valid` | `ex_ready`) & !`hazard` & !`flush`.
- **State machine** (2 states).
  - EMPTY → FULL on an accepted instruction.
  - FULL → FULL on a simultaneous drain and accept.
  - FULL → EMPTY on a drain with no accept. This includes a hazard bubble.
  - Any state → EMPTY on `flush`.
- **Priority:** `flush` beats hazard, hazard beats accept.
- **Illegal instructions** still pass down the pipe with `RF_wen`=`DM_wen`=0 and `id_illegal`=1. Execute raises the trap.
- **Stall counter.** `stall_count` increments once per cycle in which `if_valid` & `hazard` & `ex_ready`, and saturates at all-ones.

## Timing
- Latency is 1 cycle from IF acceptance to `id_valid`. Back-to-back throughput is 1 instruction per cycle.
- A load-use pair costs exactly one bubble. The dependent instruction is accepted the cycle after the load drains.
- If `ex_ready`=0 the bundle holds stable and `if_ready`=0. Outputs must not change while `id_valid` & !`ex_ready`.
- `flush` takes effect at the next edge: `id_valid`=0, and the instruction offered in the flush cycle is discarded.
- **Reset:** every output register is cleared, so all bundle fields, `id_pc`, `id_valid`, `id_illegal` and `stall_count` read 0. `if_ready` then follows its equation and reads 1 while `flush`=0. Reset asserted mid-transfer drops the held instruction.

## Structure
- Shared package `core_pkg`:
  - `opcode_t`, the funct3/funct7 constants and the ALU codes, including the M codes.
  - The operand-select and write-back-source constants.
  - `ctrl_bundle_t`, a packed struct of all bundle fields.
  - `id_state_t`.
- One sub-module, `instr_decoder`: purely combinational, `M_EXT` parameter, produces `ctrl_bundle_t`, `illegal`, `uses_rs1` and `uses_rs2`.

## Test plan
- **Throughput:** stream `addi x1,x0,5`, then `add x2,x1,x1` (`ex_ready`=1) → `id_valid` 1 on consecutive cycles. `ALU_Operation` reads 0 (`ALU_ADD`) for both; `RF_rsel2` reads 0 for the addi and 1 for the add.
- **Load-use:** `lw x5,0(x2)`, then `add x6,x5,x1` → one cycle with `if_ready`=0 and `id_valid`=0 after the lw drains, the add is accepted next cycle, `stall_count`=1. Repeat with `add x6,x7,x1` → no bubble.
- **Back-pressure:** hold `ex_ready`=0 for 3 cycles with `beq` held → bundle stable, `branch_condition`=3'b000, `if_ready`=0. Release → it drains.
- **Flush:** `flush` asserted while FULL with `if_valid`=1 → next cycle `id_valid`=0 and the offered instruction never appears. `flush` together with a hazard → no stall counted.
- **M extension:** `mul x3,x1,x2` with `M_EXT`=1 → `ALU_Operation`=16, `id_illegal`=0. With `M_EXT`=0 → `id_illegal`=1, `RF_wen`=0. Opcode 7'h7F → `id_illegal`=1.
- **Reset:** `rst_n` low mid-stream, asynchronously → outputs 0 immediately. `stall_count` forced to all-ones holds under further hazards.
